// File: rtl/data_memory_mp.sv
// Multi-port data memory: N_RD registered read ports, N_WR write ports (highest index wins), hardware clear sweep.
// Optional write-first forwarding under `DMEM_FWD_EN; the default build is read-first.
module data_memory_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int N_RD   = 4,
  parameter int N_WR   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  input  logic [N_WR-1:0]          wr_en,
  output logic                     wr_coll
);

  localparam logic [0:0]        ST_CLEAR = 1'b0;
  localparam logic [0:0]        ST_READY = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [0:0]              state;
  logic [ADDR_W-1:0]       clr_ptr;
  logic                    ready;
  logic [N_WR-1:0]         wr_ok;
  logic                    coll;
  logic [N_RD*DATA_W-1:0]  rd_next;

  assign ready = (state == ST_READY);
  assign busy  = ~ready;

  // A write is live only in READY and only inside the implemented range.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < N_WR; j++) begin
      wr_ok[j] = ready && wr_en[j] && ({1'b0, wr_addr[j*ADDR_W +: ADDR_W]} < DEPTH_X);
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int j = 0; j < N_WR; j++) begin
      for (int k = j + 1; k < N_WR; k++) begin
        if (wr_ok[j] && wr_ok[k] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])) begin
          coll = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (ready && ({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < DEPTH_X)) begin
        rd_next[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
      end
`ifdef DMEM_FWD_EN
      // Ascending scan so the highest-index writer is the one forwarded.
      for (int j = 0; j < N_WR; j++) begin
        if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_next[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      rd_data <= '0;
      wr_coll <= 1'b0;
    end else begin
      rd_data <= rd_next;
      wr_coll <= coll;
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST) begin
            state <= ST_READY;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  // Later loop iterations override earlier ones, giving the highest write port priority.
  always_ff @(posedge clock) begin
    if (!ready) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int j = 0; j < N_WR; j++) begin
        if (wr_ok[j]) begin
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_mp.sv
// Directed bench for data_memory_mp: clear sweep, reads, write priority, forwarding, range, restart.
module tb_data_memory_mp;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              clear_req, clear_req2;
  logic              busy, busy2;
  logic [NR*AW-1:0]  rd_addr, rd_addr2;
  logic [NR*DW-1:0]  rd_data, rd_data2;
  logic [NW*AW-1:0]  wr_addr, wr_addr2;
  logic [NW*DW-1:0]  wr_data, wr_data2;
  logic [NW-1:0]     wr_en, wr_en2;
  logic              wr_coll, wr_coll2;

  int tests = 0;
  int fails = 0;

  data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .N_RD(NR), .N_WR(NW)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .wr_coll(wr_coll)
  );

  data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(300), .N_RD(NR), .N_WR(NW)) dut_small (
    .clock(clock), .reset(reset), .clear_req(clear_req2), .busy(busy2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_en(wr_en2), .wr_coll(wr_coll2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    tests++; if (busy !== 1'b1)        begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
    tests++; if (rd_data !== '0)       begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    tests++; if (wr_coll !== 1'b0)     begin fails++; $display("FAIL reset_wr_coll: got %b expected 0", wr_coll); end
    tests++; if (busy2 !== 1'b1)       begin fails++; $display("FAIL reset_busy_small: got %b expected 1", busy2); end
  endtask

  task automatic test_clear_sweep();
    int n = 0;
    int n2 = 0;
    reset = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      step();
      n++;
      if (busy2 === 1'b1) n2++;
    end
    tests++; if (n != 512) begin fails++; $display("FAIL sweep_len: got %0d cycles expected 512", n); end
    tests++; if (n2 != 299) begin fails++; $display("FAIL sweep_len_small: got %0d busy cycles after first edge expected 299", n2); end
    rd_addr = {9'h1FF, 9'h100, 9'h005, 9'h000};
    step();
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL sweep_read_zero: got %h expected 0", rd_data); end
  endtask

  task automatic test_write_read();
    set_wr(0, 9'h010, 8'hA5);
    wr_en = 4'b0001;
    step();
    wr_en = 4'b0000;
    rd_addr[3*AW +: AW] = 9'h010;
    step();
    tests++; if (rd_data[3*DW +: DW] !== 8'hA5) begin fails++; $display("FAIL write_read: got %h expected a5", rd_data[3*DW +: DW]); end
  endtask

  task automatic test_collision();
    set_wr(0, 9'h020, 8'h11);
    set_wr(1, 9'h020, 8'h44);
    set_wr(2, 9'h020, 8'h22);
    set_wr(3, 9'h020, 8'h33);
    wr_en = 4'b1101;
    step();
    tests++; if (wr_coll !== 1'b1) begin fails++; $display("FAIL coll_pulse: got %b expected 1", wr_coll); end
    wr_en = 4'b0000;
    rd_addr[0*AW +: AW] = 9'h020;
    step();
    tests++; if (wr_coll !== 1'b0) begin fails++; $display("FAIL coll_one_cycle: got %b expected 0", wr_coll); end
    tests++; if (rd_data[0*DW +: DW] !== 8'h33) begin fails++; $display("FAIL coll_winner: got %h expected 33", rd_data[0*DW +: DW]); end
    // Distinct addresses in one cycle: all commit, no collision.
    set_wr(0, 9'h050, 8'h01);
    set_wr(1, 9'h051, 8'h02);
    set_wr(2, 9'h052, 8'h03);
    set_wr(3, 9'h053, 8'h04);
    wr_en = 4'b1111;
    step();
    tests++; if (wr_coll !== 1'b0) begin fails++; $display("FAIL distinct_no_coll: got %b expected 0", wr_coll); end
    wr_en = 4'b0000;
    rd_addr = {9'h053, 9'h052, 9'h051, 9'h050};
    step();
    tests++; if (rd_data !== 32'h04030201) begin fails++; $display("FAIL distinct_commit: got %h expected 04030201", rd_data); end
  endtask

  task automatic test_rd_during_wr();
    logic [DW-1:0] exp_now;
`ifdef DMEM_FWD_EN
    exp_now = 8'hC3;
`else
    exp_now = 8'h5A;
`endif
    set_wr(0, 9'h030, 8'h5A);
    wr_en = 4'b0001;
    step();
    set_wr(1, 9'h030, 8'hC3);
    wr_en = 4'b0010;
    rd_addr[2*AW +: AW] = 9'h030;
    step();
    tests++; if (rd_data[2*DW +: DW] !== exp_now) begin fails++; $display("FAIL rdw_same_cycle: got %h expected %h", rd_data[2*DW +: DW], exp_now); end
    wr_en = 4'b0000;
    step();
    tests++; if (rd_data[2*DW +: DW] !== 8'hC3) begin fails++; $display("FAIL rdw_next_cycle: got %h expected c3", rd_data[2*DW +: DW]); end
  endtask

  task automatic test_out_of_range();
    wr_addr2 = {9'h000, 9'h12B, 9'h1FF, 9'h1FF};
    wr_data2 = {8'h00, 8'h77, 8'hEE, 8'hFF};
    wr_en2 = 4'b0111;
    step();
    tests++; if (wr_coll2 !== 1'b0) begin fails++; $display("FAIL oor_no_coll: got %b expected 0", wr_coll2); end
    tests++; if (busy2 !== 1'b0)    begin fails++; $display("FAIL oor_busy: got %b expected 0", busy2); end
    wr_en2 = 4'b0000;
    rd_addr2 = {9'h000, 9'h000, 9'h12B, 9'h1FF};
    step();
    tests++; if (rd_data2[0*DW +: DW] !== 8'h00) begin fails++; $display("FAIL oor_read: got %h expected 00", rd_data2[0*DW +: DW]); end
    tests++; if (rd_data2[1*DW +: DW] !== 8'h77) begin fails++; $display("FAIL last_word: got %h expected 77", rd_data2[1*DW +: DW]); end
  endtask

  task automatic test_clear_restart();
    int n = 0;
    int bad = 0;
    set_wr(0, 9'h040, 8'h99);
    wr_en = 4'b0001;
    rd_addr[0*AW +: AW] = 9'h010;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wr_en = 4'b0000;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clr_busy: got %b expected 1", busy); end
    tests++; if (rd_data[0*DW +: DW] !== 8'hA5) begin fails++; $display("FAIL clr_last_read: got %h expected a5", rd_data[0*DW +: DW]); end
    // Writes during the sweep, including a would-be collision on address 3.
    set_wr(0, 9'h000, 8'hEE);
    set_wr(1, 9'h001, 8'hEE);
    set_wr(2, 9'h003, 8'hEE);
    set_wr(3, 9'h003, 8'hEF);
    wr_en = 4'b1111;
    step();
    tests++; if (rd_data[0*DW +: DW] !== 8'h00) begin fails++; $display("FAIL clr_rd_forced: got %h expected 00", rd_data[0*DW +: DW]); end
    tests++; if (wr_coll !== 1'b0) begin fails++; $display("FAIL clr_coll_held: got %b expected 0", wr_coll); end
    for (int c = 2; c < 100; c++) step();
    reset = 1'b1;
    step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
    reset = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      step();
      n++;
    end
    tests++; if (n != 512) begin fails++; $display("FAIL restart_len: got %0d cycles expected 512", n); end
    wr_en = 4'b0000;
    for (int a = 0; a < 512; a += 4) begin
      rd_addr = {AW'(a + 3), AW'(a + 2), AW'(a + 1), AW'(a)};
      step();
      if (rd_data !== '0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL all_zero: got %0d nonzero groups expected 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    clear_req = 1'b0;  clear_req2 = 1'b0;
    rd_addr = '0;      rd_addr2 = '0;
    wr_addr = '0;      wr_addr2 = '0;
    wr_data = '0;      wr_data2 = '0;
    wr_en = '0;        wr_en2 = '0;
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_collision();
    test_rd_during_wr();
    test_out_of_range();
    test_clear_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
